sram_mem_responder: RTL and testbench
=====================================

// Module: sram_mem_responder
// PURPOSE
//  Memory-side responder for the pipeline's MEM stage: accepts one 32-bit load/store
//  request at a time and services it on an external 16-bit asynchronous SRAM as two
//  half-word accesses. Drops ready while busy so the pipeline freezes all stage regs.
//  Sits between the MEM stage (address = ALU result, writedata = store operand) and the pins.
// PARAMETERS
//  ACCESS_CYC  2     cycles each half-word access is held on the SRAM pins (>=1)
//  DATA_BASE   1024  byte address mapped to SRAM word 0 (subtracted before mapping)
// PORTS
//  clk        in    1   system clock, all state on rising edge
//  rst        in    1   synchronous, active-high reset
//  rd_en      in    1   load request (from MEM stage MEM_R_En)
//  wr_en      in    1   store request (from MEM stage MEM_W_En)
//  address    in    32  byte address of the 32-bit word (bits [1:0] ignored)
//  writedata  in    32  store data
//  readdata   out   32  load result, valid from the ready=1 completion cycle, held until next load completes
//  ready      out   1   1 = no transaction pending/complete this cycle; 0 = pipeline must stall
//  SRAM_DQ    inout 16  SRAM data bus
//  SRAM_ADDR  out   18  SRAM half-word address
//  SRAM_WE_N  out   1   SRAM write strobe, active low
//  SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  out 1 each, tied 0
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0, readdata=0, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
//  States: IDLE -> LOW -> HIGH -> DONE -> IDLE.
//  - IDLE: if (rd_en|wr_en) latch address/writedata/op, ready=0 (combinational, same cycle),
//    next=LOW; else ready=1, stay. wr_en&rd_en together: write wins, no read performed.
//  - LOW: ACCESS_CYC cycles on low half; HIGH: ACCESS_CYC cycles on high half; ready=0.
//  - DONE: one cycle, ready=1, readdata updated (loads only); next=IDLE.
//  - Total: ready low 2*ACCESS_CYC+1 cycles, high on cycle 2*ACCESS_CYC+1 after request.
//  Address map: w = (addr_latched - DATA_BASE) >> 2, 17 bits (truncate, no range check);
//    SRAM_ADDR = {w,1'b0} in LOW, {w,1'b1} in HIGH, 0 in IDLE/DONE.
//  Write: SRAM_DQ = wdata[15:0] in LOW, wdata[31:16] in HIGH; SRAM_WE_N=0 for all cycles
//    of LOW/HIGH; DQ = Z and WE_N = 1 in every other state and all read transactions.
//  Read: sample SRAM_DQ on last cycle of LOW into lo, of HIGH into hi; readdata={hi,lo} at DONE.
//  Requester holds rd_en/wr_en/address/writedata stable while ready=0; inputs ignored outside IDLE.
//  The DONE cycle advances the pipeline; next request is seen in IDLE the following cycle
//    (no re-trigger of the completed request, one idle/bubble cycle minimum between transactions).
//  Reset mid-transaction: next cycle IDLE, WE_N=1, DQ released, readdata=0, transaction dropped.
//  Wait counter counts 0..ACCESS_CYC-1 per phase, cleared on phase entry.
// TESTING
//  (Bench: async SRAM model, combinational read, write on WE_N low; ACCESS_CYC=2, DATA_BASE=1024.)
//  1 store wr_en addr=1024 wdata=0xDEADBEEF -> ready=0 5 cycles, SRAM[0]=0xBEEF, SRAM[1]=0xDEAD, ready=1 cycle 5.
//  2 load rd_en addr=1024 after test 1 -> readdata=0xDEADBEEF in DONE cycle, DQ never driven by DUT.
//  3 store addr=1028 0x12345678 then immediate load addr=1028 -> SRAM_ADDR 2,3; readdata=0x12345678; idle gap 1 cycle.
//  4 rd_en&wr_en both at addr=1032 data 0xA5A5_5A5A -> write performed, readdata unchanged.
//  5 rst asserted in HIGH of a store -> next cycle IDLE, WE_N=1, DQ=Z, ready=1, readdata=0.
//  6 no request for 10 cycles -> ready=1, WE_N=1, SRAM_ADDR=0 throughout; vary ACCESS_CYC=1 -> 3-cycle stall.

Source files
------------

// File: rtl/sram_mem_responder.sv
// Memory-side responder for the MEM stage. Services one 32-bit load or store
// as two half-word accesses on a 16-bit asynchronous SRAM, low half first.
// ready drops while a transaction is in flight so the pipeline stalls.
module sram_mem_responder #(
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned DATA_BASE  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int unsigned CntW = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYC - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [16:0]     word_q;
  logic [31:0]     wdata_q;
  logic            is_wr_q;
  logic [15:0]     lo_q;
  logic [31:0]     readdata_q;

  logic            req;
  logic            phase_end;
  logic            in_access;
  logic [31:0]     offset;
  logic [15:0]     dq_out;
  logic            unused_offset_bits;

  assign req       = rd_en | wr_en;
  assign offset    = address - DATA_BASE;
  assign phase_end = (cnt_q == CntLast);
  assign in_access = (state_q == StLow) || (state_q == StHigh);

  // Only bits [18:2] of the rebased address select an SRAM word; no range check.
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // Next-state and per-phase wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLow;
          cnt_d   = '0;
        end
      end
      StLow: begin
        if (phase_end) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (phase_end) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // Done lasts one cycle; the request is not re-examined until Idle.
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      lo_q       <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req) begin
        word_q  <= offset[18:2];
        wdata_q <= writedata;
        is_wr_q <= wr_en;  // write wins when both are asserted
      end
      if (state_q == StLow && phase_end && !is_wr_q) begin
        lo_q <= SRAM_DQ;
      end
      // Assemble the word on the last high-phase cycle so it is valid in Done.
      if (state_q == StHigh && phase_end && !is_wr_q) begin
        readdata_q <= {SRAM_DQ, lo_q};
      end
    end
  end

  // Pin and handshake outputs decoded from the current state.
  always_comb begin
    ready     = ((state_q == StIdle) && !req) || (state_q == StDone);
    SRAM_ADDR = in_access ? {word_q, (state_q == StHigh)} : 18'd0;
    SRAM_WE_N = !(in_access && is_wr_q);
    dq_out    = (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
  end

  assign SRAM_DQ   = SRAM_WE_N ? 16'hzzzz : dq_out;
  assign readdata  = readdata_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench: two responders (ACCESS_CYC=2 and 1) each on its own
// asynchronous SRAM model with combinational read and write while WE_N is low.
module tb_sram_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en     [2];
  logic        wr_en     [2];
  logic [31:0] address   [2];
  logic [31:0] writedata [2];
  logic [31:0] readdata  [2];
  logic        ready     [2];
  logic [17:0] sram_addr [2];
  logic        we_n      [2];
  logic        ce_n      [2];
  logic        oe_n      [2];
  logic        ub_n      [2];
  logic        lb_n      [2];
  wire  [15:0] dq0;
  wire  [15:0] dq1;

  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_mem_responder #(.ACCESS_CYC(2), .DATA_BASE(1024)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]), .address(address[0]),
    .writedata(writedata[0]), .readdata(readdata[0]), .ready(ready[0]), .SRAM_DQ(dq0),
    .SRAM_ADDR(sram_addr[0]), .SRAM_WE_N(we_n[0]), .SRAM_CE_N(ce_n[0]),
    .SRAM_OE_N(oe_n[0]), .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0])
  );

  sram_mem_responder #(.ACCESS_CYC(1), .DATA_BASE(1024)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]), .address(address[1]),
    .writedata(writedata[1]), .readdata(readdata[1]), .ready(ready[1]), .SRAM_DQ(dq1),
    .SRAM_ADDR(sram_addr[1]), .SRAM_WE_N(we_n[1]), .SRAM_CE_N(ce_n[1]),
    .SRAM_OE_N(oe_n[1]), .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1])
  );

  // SRAM models: drive the bus only while the responder is not writing.
  assign dq0 = we_n[0] ? mem0[sram_addr[0][5:0]] : 16'hzzzz;
  assign dq1 = we_n[1] ? mem1[sram_addr[1][5:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!we_n[0]) mem0[sram_addr[0][5:0]] <= dq0;
    if (!we_n[1]) mem1[sram_addr[1][5:0]] <= dq1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on responder d; counts cycles with ready low starting at the
  // request cycle, and records pin activity along the way.
  task automatic txn(input int d, input int acc, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] data,
                     output int stall, output logic [31:0] rdata,
                     output logic [17:0] alo, output logic [17:0] ahi, output int we_cnt);
    @(negedge clk);
    rd_en[d] = rd; wr_en[d] = wr; address[d] = addr; writedata[d] = data;
    stall = 0; we_cnt = 0; alo = '1; ahi = '1;
    #1;
    while (!ready[d] && stall < 50) begin
      if (!we_n[d]) we_cnt++;
      if (stall == 1) alo = sram_addr[d];
      if (stall == acc + 1) ahi = sram_addr[d];
      stall++;
      @(negedge clk);
      #1;
    end
    rdata = readdata[d];
    rd_en[d] = 1'b0; wr_en[d] = 1'b0;
  endtask

  initial begin
    int          stall, wec;
    logic [31:0] rdata;
    logic [17:0] alo, ahi;

    for (int i = 0; i < 64; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    for (int d = 0; d < 2; d++) begin
      rd_en[d] = 1'b0; wr_en[d] = 1'b0; address[d] = '0; writedata[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(ready[d]), 32'd1);
      check("rst_we_n", 32'(we_n[d]), 32'd1);
      check("rst_readdata", readdata[d], 32'd0);
      check("rst_addr", 32'(sram_addr[d]), 32'd0);
    end

    // 1: store 0xDEADBEEF at 1024
    txn(0, 2, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, stall, rdata, alo, ahi, wec);
    check("t1_stall", 32'(stall), 32'd5);
    check("t1_we_cycles", 32'(wec), 32'd4);
    check("t1_addr_lo", 32'(alo), 32'd0);
    check("t1_addr_hi", 32'(ahi), 32'd1);
    check("t1_mem0", 32'(mem0[0]), 32'h0000BEEF);
    check("t1_mem1", 32'(mem0[1]), 32'h0000DEAD);

    // 2: load it back; the DUT must never drive DQ
    txn(0, 2, 1'b1, 1'b0, 32'd1024, 32'h0, stall, rdata, alo, ahi, wec);
    check("t2_stall", 32'(stall), 32'd5);
    check("t2_readdata", rdata, 32'hDEADBEEF);
    check("t2_we_cycles", 32'(wec), 32'd0);

    // 3: store then back-to-back load at 1028
    txn(0, 2, 1'b0, 1'b1, 32'd1028, 32'h12345678, stall, rdata, alo, ahi, wec);
    check("t3_st_addr_lo", 32'(alo), 32'd2);
    check("t3_st_addr_hi", 32'(ahi), 32'd3);
    txn(0, 2, 1'b1, 1'b0, 32'd1028, 32'h0, stall, rdata, alo, ahi, wec);
    check("t3_ld_stall", 32'(stall), 32'd5);
    check("t3_ld_addr_lo", 32'(alo), 32'd2);
    check("t3_readdata", rdata, 32'h12345678);

    // 4: rd_en and wr_en together -> write only
    txn(0, 2, 1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, stall, rdata, alo, ahi, wec);
    check("t4_stall", 32'(stall), 32'd5);
    check("t4_readdata_kept", rdata, 32'h12345678);
    check("t4_we_cycles", 32'(wec), 32'd4);
    check("t4_mem_lo", 32'(mem0[4]), 32'h00005A5A);
    check("t4_mem_hi", 32'(mem0[5]), 32'h0000A5A5);
    txn(0, 2, 1'b1, 1'b0, 32'd1032, 32'h0, stall, rdata, alo, ahi, wec);
    check("t4_readback", rdata, 32'hA5A55A5A);

    // 5: reset during the high phase of a store
    @(negedge clk);
    wr_en[0] = 1'b1; address[0] = 32'd1036; writedata[0] = 32'h11112222;
    repeat (3) @(negedge clk);
    #1;
    check("t5_in_high_addr", 32'(sram_addr[0]), 32'd7);
    check("t5_in_high_we_n", 32'(we_n[0]), 32'd0);
    rst = 1'b1; wr_en[0] = 1'b0;
    @(negedge clk);
    #1;
    check("t5_we_n", 32'(we_n[0]), 32'd1);
    check("t5_ready", 32'(ready[0]), 32'd1);
    check("t5_readdata", readdata[0], 32'd0);
    check("t5_addr", 32'(sram_addr[0]), 32'd0);
    check("t5_dq_released", 32'(dq0), 32'(mem0[0]));
    rst = 1'b0;

    // 6: idle for 10 cycles: {ready, we_n, addr} stays {1, 1, 0}
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("t6_idle", {12'd0, ready[0], we_n[0], sram_addr[0]}, {12'd0, 1'b1, 1'b1, 18'd0});
    end

    // 6b: ACCESS_CYC=1 gives a 3-cycle stall
    txn(1, 1, 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, stall, rdata, alo, ahi, wec);
    check("t6b_st_stall", 32'(stall), 32'd3);
    check("t6b_addr_lo", 32'(alo), 32'd4);
    check("t6b_addr_hi", 32'(ahi), 32'd5);
    check("t6b_we_cycles", 32'(wec), 32'd2);
    check("t6b_mem_lo", 32'(mem1[4]), 32'h0000F00D);
    check("t6b_mem_hi", 32'(mem1[5]), 32'h0000CAFE);
    txn(1, 1, 1'b1, 1'b0, 32'd1032, 32'h0, stall, rdata, alo, ahi, wec);
    check("t6b_ld_stall", 32'(stall), 32'd3);
    check("t6b_readdata", rdata, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
